// File: rtl/ddr_tx_serializer.sv
// ---------------------------------------------------------------------------
// ddr_tx_serializer
//
// Transmit datapath of the HDR-DDR engine. For each pattern mode it drives a
// fixed bit sequence onto SDA, one bit per bit tick, and keeps a running
// PA1/PA0 parity word and a CRC5 (x^5 + x^2 + 1) over the data bits.
//
// Request protocol: i_tx_en acts as a level "valid" from the control FSM.
// While the serializer is IDLE, a high i_tx_en is accepted immediately
// (IDLE is the "ready" condition) and i_tx_mode plus the register-file
// operands are sampled in that same cycle. i_tx_en must then stay high until
// the one-cycle o_tx_mode_done pulse; dropping it earlier aborts the mode.
// i_tx_en is ignored during the DONE cycle, so the control FSM can present
// the next mode there and it is loaded in the following IDLE cycle.
//
// Ports:
//   i_sys_clk        system clock
//   i_sys_rst        asynchronous active-low reset
//   i_tx_en          serializer request (level)
//   i_tx_mode[3:0]   pattern select, sampled at load
//   i_bit_tick       one-cycle pulse per SDA bit slot
//   i_regf_cmd[7:0]  {rnw, cmd[6:0]}
//   i_regf_addr[6:0] target address
//   i_regf_data[15:0] data word
//   o_sda            registered SDA level
//   o_tx_mode_done   one-cycle pulse when a mode completes
//   o_tx_parity_data 1 = parity context is a data word, 0 = command/address
//   o_busy           high in SHIFT and DONE
//   o_dbg_state[1:0] current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// ---------------------------------------------------------------------------
module ddr_tx_serializer (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_tx_en,
    input  logic [3:0]  i_tx_mode,
    input  logic        i_bit_tick,
    input  logic [7:0]  i_regf_cmd,
    input  logic [6:0]  i_regf_addr,
    input  logic [15:0] i_regf_data,
    output logic        o_sda,
    output logic        o_tx_mode_done,
    output logic        o_tx_parity_data,
    output logic        o_busy,
    output logic [1:0]  o_dbg_state
);

    localparam logic [3:0] MODE_CMD     = 4'b0000;
    localparam logic [3:0] MODE_SPECIAL = 4'b0001;
    localparam logic [3:0] MODE_ONE     = 4'b0010;
    localparam logic [3:0] MODE_ZERO    = 4'b0011;
    localparam logic [3:0] MODE_DATA    = 4'b0100;
    localparam logic [3:0] MODE_PARITY  = 4'b0101;
    localparam logic [3:0] MODE_TOKEN   = 4'b0110;
    localparam logic [3:0] MODE_CRC     = 4'b0111;
    localparam logic [3:0] MODE_RESTART = 4'b1000;
    localparam logic [3:0] MODE_EXIT    = 4'b1001;
    localparam logic [3:0] MODE_ADDR    = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  mode_q, mode_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic        sda_q, sda_d;
    logic [15:0] pw_q, pw_d;
    logic [4:0]  crc_q, crc_d;
    logic        pdata_q, pdata_d;

    logic        load;
    logic        shift_tick;
    logic        abort;
    logic [15:0] load_pat;
    logic [3:0]  load_len_m1;
    logic        pa1;
    logic        pa0;
    logic        crc_fb;

    assign load       = (state_q == ST_IDLE) && i_tx_en;
    assign shift_tick = (state_q == ST_SHIFT) && i_tx_en && i_bit_tick;
    assign abort      = (state_q == ST_SHIFT) && !i_tx_en;

    assign pa1 = pw_q[15] ^ pw_q[13] ^ pw_q[11] ^ pw_q[9]
               ^ pw_q[7]  ^ pw_q[5]  ^ pw_q[3]  ^ pw_q[1];
    assign pa0 = pw_q[14] ^ pw_q[12] ^ pw_q[10] ^ pw_q[8]
               ^ pw_q[6]  ^ pw_q[4]  ^ pw_q[2]  ^ pw_q[0] ^ 1'b1;

    // The bit leaving SDA on this tick is the one currently registered.
    assign crc_fb = crc_q[4] ^ sda_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. An enable drop wins over a coincident tick.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_tx_en) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!i_tx_en) begin
                    state_d = ST_IDLE;
                end else if (i_bit_tick && (bitcnt_q == 4'd0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_tx_mode_done = (state_q == ST_DONE);
        o_busy         = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        o_dbg_state    = state_q;
    end

    assign o_sda            = sda_q;
    assign o_tx_parity_data = pdata_q;

    // ------------------------------------------------------------------
    // Pattern table: left-aligned bits (first bit in [15]) and length - 1.
    // ------------------------------------------------------------------
    always_comb begin
        load_pat    = 16'h8000;
        load_len_m1 = 4'd0;
        case (i_tx_mode)
            MODE_CMD:     begin load_pat = {i_regf_cmd, 8'h00};               load_len_m1 = 4'd7;  end
            MODE_ADDR:    begin load_pat = {i_regf_addr, 1'b0, 8'h00};        load_len_m1 = 4'd7;  end
            MODE_SPECIAL: begin load_pat = {2'b01, 14'h0000};                 load_len_m1 = 4'd1;  end
            MODE_ONE:     begin load_pat = 16'h8000;                          load_len_m1 = 4'd0;  end
            MODE_ZERO:    begin load_pat = 16'h0000;                          load_len_m1 = 4'd0;  end
            MODE_DATA:    begin load_pat = i_regf_data;                       load_len_m1 = 4'd15; end
            MODE_PARITY:  begin load_pat = {pa1, pa0, 14'h0000};              load_len_m1 = 4'd1;  end
            MODE_TOKEN:   begin load_pat = {4'b1100, 12'h000};                load_len_m1 = 4'd3;  end
            MODE_CRC:     begin load_pat = {crc_q, 11'h000};                  load_len_m1 = 4'd4;  end
            MODE_RESTART: begin load_pat = {4'b0101, 12'h000};                load_len_m1 = 4'd3;  end
            MODE_EXIT:    begin load_pat = {8'b01010101, 8'h00};              load_len_m1 = 4'd7;  end
            default:      begin load_pat = 16'h8000;                          load_len_m1 = 4'd0;  end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        mode_d   = mode_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sda_d    = sda_q;
        pw_d     = pw_q;
        crc_d    = crc_q;
        pdata_d  = pdata_q;

        if (load) begin
            mode_d   = i_tx_mode;
            sda_d    = load_pat[15];
            shreg_d  = load_pat << 1;
            bitcnt_d = load_len_m1;
            case (i_tx_mode)
                MODE_CMD: begin
                    pw_d[15:8] = i_regf_cmd;
                    crc_d      = 5'b11111;
                    pdata_d    = 1'b0;
                end
                MODE_ADDR: begin
                    pw_d[7:0] = {i_regf_addr, 1'b0};
                end
                MODE_DATA: begin
                    pw_d    = i_regf_data;
                    pdata_d = 1'b1;
                end
                default: begin
                end
            endcase
        end

        // Abort leaves parity word and CRC with whatever they had reached.
        if (abort) begin
            sda_d = 1'b1;
        end

        if (shift_tick) begin
            if (mode_q == MODE_DATA) begin
                crc_d = {crc_q[3], crc_q[2], crc_q[1] ^ crc_fb, crc_q[0], crc_fb};
            end
            // On the closing tick SDA keeps the last bit through DONE/IDLE.
            if (bitcnt_q != 4'd0) begin
                sda_d    = shreg_q[15];
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            mode_q   <= 4'd0;
            shreg_q  <= 16'h0000;
            bitcnt_q <= 4'd0;
            sda_q    <= 1'b1;
            pw_q     <= 16'h0000;
            crc_q    <= 5'b11111;
            pdata_q  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sda_q    <= sda_d;
            pw_q     <= pw_d;
            crc_q    <= crc_d;
            pdata_q  <= pdata_d;
        end
    end

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_ddr_tx_serializer
//
// Bench for ddr_tx_serializer. A reference model of the parity word, CRC5
// and parity-context flag builds each mode's expected SDA sequence, which is
// pushed into exp_q at load and popped as each bit appears on SDA.
// ---------------------------------------------------------------------------
module tb_ddr_tx_serializer;

    localparam logic [3:0] M_CMD     = 4'b0000;
    localparam logic [3:0] M_SPECIAL = 4'b0001;
    localparam logic [3:0] M_ONE     = 4'b0010;
    localparam logic [3:0] M_ZERO    = 4'b0011;
    localparam logic [3:0] M_DATA    = 4'b0100;
    localparam logic [3:0] M_PARITY  = 4'b0101;
    localparam logic [3:0] M_TOKEN   = 4'b0110;
    localparam logic [3:0] M_CRC     = 4'b0111;
    localparam logic [3:0] M_RESTART = 4'b1000;
    localparam logic [3:0] M_EXIT    = 4'b1001;
    localparam logic [3:0] M_ADDR    = 4'b1010;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_en = 1'b0;
    logic [3:0]  tx_mode = 4'd0;
    logic        bit_tick = 1'b0;
    logic [7:0]  regf_cmd = 8'h00;
    logic [6:0]  regf_addr = 7'h00;
    logic [15:0] regf_data = 16'h0000;
    logic        o_sda;
    logic        o_tx_mode_done;
    logic        o_tx_parity_data;
    logic        o_busy;
    logic [1:0]  o_dbg_state;

    always #5 clk = ~clk;

    ddr_tx_serializer dut (
        .i_sys_clk        (clk),
        .i_sys_rst        (rst_n),
        .i_tx_en          (tx_en),
        .i_tx_mode        (tx_mode),
        .i_bit_tick       (bit_tick),
        .i_regf_cmd       (regf_cmd),
        .i_regf_addr      (regf_addr),
        .i_regf_data      (regf_data),
        .o_sda            (o_sda),
        .o_tx_mode_done   (o_tx_mode_done),
        .o_tx_parity_data (o_tx_parity_data),
        .o_busy           (o_busy),
        .o_dbg_state      (o_dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          done_cnt = 0;
    logic [0:0]  exp_q[$];
    logic [15:0] m_pw = 16'h0000;
    logic [4:0]  m_crc = 5'b11111;
    logic        m_pdata = 1'b0;

    always @(negedge clk) begin
        if (o_tx_mode_done === 1'b1) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic m_crc_feed(input logic b);
        logic fb;
        fb = m_crc[4] ^ b;
        m_crc = {m_crc[3], m_crc[2], m_crc[1] ^ fb, m_crc[0], fb};
    endtask

    task automatic build_seq(input logic [3:0] mode, output logic [15:0] seq, output int len);
        logic p1;
        logic p0;
        p1 = 1'b0;
        p0 = 1'b1;
        for (int i = 0; i < 16; i += 2) begin
            p0 = p0 ^ m_pw[i];
            p1 = p1 ^ m_pw[i+1];
        end
        case (mode)
            M_CMD:     begin seq = {regf_cmd, 8'h00};          len = 8;  end
            M_ADDR:    begin seq = {regf_addr, 1'b0, 8'h00};   len = 8;  end
            M_SPECIAL: begin seq = 16'b0100_0000_0000_0000;    len = 2;  end
            M_ONE:     begin seq = 16'b1000_0000_0000_0000;    len = 1;  end
            M_ZERO:    begin seq = 16'b0000_0000_0000_0000;    len = 1;  end
            M_DATA:    begin seq = regf_data;                  len = 16; end
            M_PARITY:  begin seq = {p1, p0, 14'h0000};         len = 2;  end
            M_TOKEN:   begin seq = 16'b1100_0000_0000_0000;    len = 4;  end
            M_CRC:     begin seq = {m_crc, 11'h000};           len = 5;  end
            M_RESTART: begin seq = 16'b0101_0000_0000_0000;    len = 4;  end
            M_EXIT:    begin seq = 16'b0101_0101_0000_0000;    len = 8;  end
            default:   begin seq = 16'b1000_0000_0000_0000;    len = 1;  end
        endcase
    endtask

    // ------------------------------------------------------------------
    // Driver: load one mode and tick through it, checking every bit.
    // stop_after > 0 interrupts before tick number stop_after, either by
    // dropping tx_en or by asserting reset.
    // ------------------------------------------------------------------
    task automatic drive_mode(input logic [3:0] mode, input bit keep_en,
                              input int stop_after, input bit stop_by_reset);
        logic [15:0] seq;
        int          len;
        int          guard;
        logic [0:0]  exp_b;

        build_seq(mode, seq, len);
        for (int i = 0; i < len; i++) exp_q.push_back(seq[15-i]);
        case (mode)
            M_CMD:  begin m_pw[15:8] = regf_cmd; m_crc = 5'b11111; m_pdata = 1'b0; end
            M_ADDR: begin m_pw[7:0] = {regf_addr, 1'b0}; end
            M_DATA: begin m_pw = regf_data; m_pdata = 1'b1; end
            default: begin end
        endcase

        tx_mode = mode;
        tx_en   = 1'b1;
        guard   = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (o_dbg_state !== 2'd1 && guard < 8);
        if (o_dbg_state !== 2'd1) begin
            total_cnt++;
            $display("FAIL load_timeout mode=%b: state=%0d, expected 1 within 8 cycles", mode, o_dbg_state);
            exp_q.delete();
            tx_en = 1'b0;
            return;
        end

        exp_b = exp_q.pop_front();
        total_cnt++;
        if (o_sda !== exp_b[0])
            $display("FAIL sda mode=%b bit=0: got %b, expected %b", mode, o_sda, exp_b[0]);
        else pass_cnt++;
        total_cnt++;
        if (o_tx_parity_data !== m_pdata)
            $display("FAIL parity_data mode=%b: got %b, expected %b", mode, o_tx_parity_data, m_pdata);
        else pass_cnt++;

        for (int k = 0; k < len; k++) begin
            repeat (3) @(posedge clk);
            #1;
            if (stop_after > 0 && k == stop_after) begin
                if (stop_by_reset) begin
                    #2 rst_n = 1'b0;
                    #1;
                    total_cnt++;
                    if ({o_sda, o_tx_mode_done, o_tx_parity_data, o_busy, o_dbg_state} !== 6'b100000)
                        $display("FAIL async_reset: got sda/done/pdata/busy/state=%b%b%b%b/%0d, expected 1000/0",
                                 o_sda, o_tx_mode_done, o_tx_parity_data, o_busy, o_dbg_state);
                    else pass_cnt++;
                    m_pw = 16'h0000; m_crc = 5'b11111; m_pdata = 1'b0;
                    exp_q.delete();
                    tx_en = 1'b0;
                    @(posedge clk); #3 rst_n = 1'b1;
                    @(posedge clk); #1;
                end else begin
                    tx_en = 1'b0;
                    @(posedge clk); #1;
                    total_cnt++;
                    if (o_sda !== 1'b1 || o_busy !== 1'b0 || o_tx_mode_done !== 1'b0)
                        $display("FAIL abort: got sda/busy/done=%b%b%b, expected 100", o_sda, o_busy, o_tx_mode_done);
                    else pass_cnt++;
                    exp_q.delete();
                end
                return;
            end
            bit_tick = 1'b1;
            @(posedge clk); #1;
            bit_tick = 1'b0;
            if (mode == M_DATA) m_crc_feed(seq[15-k]);
            if (k < len - 1) begin
                exp_b = exp_q.pop_front();
                total_cnt++;
                if (o_sda !== exp_b[0] || o_tx_mode_done !== 1'b0)
                    $display("FAIL sda mode=%b bit=%0d: got sda=%b done=%b, expected sda=%b done=0",
                             mode, k + 1, o_sda, o_tx_mode_done, exp_b[0]);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (o_tx_mode_done !== 1'b1)
                    $display("FAIL done_pulse mode=%b: got %b, expected 1", mode, o_tx_mode_done);
                else pass_cnt++;
                if (!keep_en) tx_en = 1'b0;
            end
        end
        @(posedge clk); #1;
        total_cnt++;
        if (o_tx_mode_done !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL done_width mode=%b: got done=%b busy=%b, expected 0 0", mode, o_tx_mode_done, o_busy);
        else pass_cnt++;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({o_sda, o_tx_mode_done, o_tx_parity_data, o_busy} !== 4'b1000)
            $display("FAIL reset_values: got sda/done/pdata/busy=%b%b%b%b, expected 1000",
                     o_sda, o_tx_mode_done, o_tx_parity_data, o_busy);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (o_busy !== 1'b0 || o_dbg_state !== 2'd0)
            $display("FAIL reset_idle: got busy=%b state=%0d, expected 0 0", o_busy, o_dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_cmd_addr_parity();
        int d0;
        d0 = done_cnt;
        regf_cmd  = 8'h80;
        regf_addr = 7'h2A;
        drive_mode(M_CMD, 1'b1, 0, 1'b0);
        drive_mode(M_ADDR, 1'b1, 0, 1'b0);
        drive_mode(M_PARITY, 1'b0, 0, 1'b0);
        total_cnt++;
        if (done_cnt - d0 != 3)
            $display("FAIL cmd_addr_parity_dones: got %0d, expected 3", done_cnt - d0);
        else pass_cnt++;
        total_cnt++;
        if (o_tx_parity_data !== 1'b0)
            $display("FAIL cmd_addr_parity_pdata: got %b, expected 0", o_tx_parity_data);
        else pass_cnt++;
    endtask

    task automatic test_data_crc();
        regf_cmd  = 8'h80;
        regf_data = 16'h0000;
        drive_mode(M_CMD, 1'b1, 0, 1'b0);
        drive_mode(M_DATA, 1'b1, 0, 1'b0);
        total_cnt++;
        if (o_tx_parity_data !== 1'b1)
            $display("FAIL data_pdata: got %b, expected 1", o_tx_parity_data);
        else pass_cnt++;
        drive_mode(M_CRC, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 3; n++) begin
            regf_cmd  = 8'($urandom_range(0, 255));
            regf_addr = 7'($urandom_range(0, 127));
            drive_mode(M_CMD, 1'b1, 0, 1'b0);
            drive_mode(M_ADDR, 1'b1, 0, 1'b0);
            drive_mode(M_PARITY, 1'b1, 0, 1'b0);
            regf_data = 16'($urandom_range(0, 65535));
            drive_mode(M_DATA, 1'b1, 0, 1'b0);
            drive_mode(M_PARITY, 1'b1, 0, 1'b0);
            drive_mode(M_TOKEN, 1'b1, 0, 1'b0);
            drive_mode(M_CRC, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        drive_mode(M_SPECIAL, 1'b1, 0, 1'b0);
        drive_mode(M_ONE, 1'b1, 0, 1'b0);
        drive_mode(M_ZERO, 1'b0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if (done_cnt - d0 != 3 || o_busy !== 1'b0)
            $display("FAIL back_to_back: got dones=%0d busy=%b, expected 3 0", done_cnt - d0, o_busy);
        else pass_cnt++;
        // A tick while idle must not disturb SDA.
        bit_tick = 1'b1;
        @(posedge clk); #1;
        bit_tick = 1'b0;
        total_cnt++;
        if (o_sda !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL idle_tick: got sda=%b busy=%b, expected 0 0", o_sda, o_busy);
        else pass_cnt++;
    endtask

    task automatic test_invalid_mode();
        // Tick on the load cycle must be ignored: a 1-bit mode stays in SHIFT.
        tx_mode  = 4'b1111;
        tx_en    = 1'b1;
        bit_tick = 1'b1;
        @(posedge clk); #1;
        bit_tick = 1'b0;
        total_cnt++;
        if (o_sda !== 1'b1 || o_dbg_state !== 2'd1 || o_tx_mode_done !== 1'b0)
            $display("FAIL invalid_load: got sda=%b state=%0d done=%b, expected 1 1 0",
                     o_sda, o_dbg_state, o_tx_mode_done);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (o_dbg_state !== 2'd1 || o_tx_mode_done !== 1'b0)
            $display("FAIL load_tick_ignored: got state=%0d done=%b, expected 1 0", o_dbg_state, o_tx_mode_done);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        bit_tick = 1'b1;
        @(posedge clk); #1;
        bit_tick = 1'b0;
        tx_en = 1'b0;
        total_cnt++;
        if (o_tx_mode_done !== 1'b1 || o_sda !== 1'b1)
            $display("FAIL invalid_done: got done=%b sda=%b, expected 1 1", o_tx_mode_done, o_sda);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (o_tx_mode_done !== 1'b0)
            $display("FAIL invalid_done_width: got %b, expected 0", o_tx_mode_done);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int d0;
        regf_cmd  = 8'h3C;
        regf_data = 16'h0000;
        drive_mode(M_CMD, 1'b0, 0, 1'b0);
        d0 = done_cnt;
        drive_mode(M_DATA, 1'b1, 3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (done_cnt != d0 || o_sda !== 1'b1)
            $display("FAIL abort_no_done: got dones=%0d sda=%b, expected 0 1", done_cnt - d0, o_sda);
        else pass_cnt++;
        // CRC after an aborted word reflects only the bits that were shifted.
        drive_mode(M_CRC, 1'b0, 0, 1'b0);
        regf_cmd = 8'($urandom_range(0, 255));
        drive_mode(M_CMD, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        drive_mode(M_EXIT, 1'b1, 5, 1'b1);
        total_cnt++;
        if (done_cnt != d0)
            $display("FAIL reset_no_done: got %0d pulses, expected 0", done_cnt - d0);
        else pass_cnt++;
        drive_mode(M_RESTART, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_cmd_addr_parity();
        test_data_crc();
        test_random_frames();
        test_back_to_back();
        test_invalid_mode();
        test_abort();
        test_reset_mid();
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
